// File: rtl/even_issue_ctrl.sv
// Even-pipe issue gate: stalls on RAW hazards against a shifting in-flight table.
// Optional macro EVEN_ISSUE_FWD_EN: results become usable after L+1 cycles instead of after writeback.
module even_issue_ctrl #(
   parameter int unsigned NUM_ENTRIES = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_unit_id,
   input  logic [6:0]  in_reg_dst,
   input  logic [3:0]  in_latency,
   input  logic        in_reg_wr,
   input  logic [6:0]  in_ra_addr,
   input  logic [6:0]  in_rb_addr,
   input  logic [6:0]  in_rc_addr,
   input  logic [2:0]  in_src_used,
   input  logic        flush,
   output logic        issue_valid,
   output logic [2:0]  issue_unit_id,
   output logic [6:0]  issue_reg_dst,
   output logic [3:0]  issue_latency,
   output logic        issue_reg_wr,
   output logic        lat_err,
   output logic [15:0] stall_cnt
);
   localparam int unsigned MAX_AGE = 9;

   logic       r_vld     [NUM_ENTRIES];
   logic [6:0] r_dst     [NUM_ENTRIES];
   logic       r_wr      [NUM_ENTRIES];
   logic [3:0] r_rdy_age [NUM_ENTRIES];

   logic        r_issue_valid;
   logic [2:0]  r_issue_unit_id;
   logic [6:0]  r_issue_reg_dst;
   logic [3:0]  r_issue_latency;
   logic        r_issue_reg_wr;
   logic        r_lat_err;
   logic [15:0] r_stall_cnt;

   logic [6:0] w_src [3];
   logic       w_hazard;
   logic       w_accept;
   logic       w_lat_ok;
   logic       w_insert;
   logic [3:0] w_rdy_age;

   assign w_src[0] = in_ra_addr;
   assign w_src[1] = in_rb_addr;
   assign w_src[2] = in_rc_addr;

`ifdef EVEN_ISSUE_FWD_EN
   assign w_rdy_age = in_latency;
`else
   assign w_rdy_age = 4'd8;
`endif

   // Slot index is the entry age: the whole table shifts one slot every edge,
   // so an entry is still busy while its slot index is below its ready age.
   always_comb begin
      w_hazard = 1'b0;
      for (int unsigned k = 0; k < NUM_ENTRIES; k++) begin
         for (int unsigned s = 0; s < 3; s++) begin
            if (in_src_used[s] && r_vld[k] && r_wr[k] &&
                (w_src[s] == r_dst[k]) && (4'(k) < r_rdy_age[k]))
               w_hazard = 1'b1;
         end
      end
   end

   assign in_ready = ~flush & ~w_hazard;
   assign w_accept = in_valid & in_ready;
   assign w_lat_ok = (in_latency >= 4'd2) && (in_latency <= 4'd7);
   assign w_insert = w_accept & w_lat_ok;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int unsigned k = 0; k < NUM_ENTRIES; k++) begin
            r_vld[k]     <= 1'b0;
            r_dst[k]     <= '0;
            r_wr[k]      <= 1'b0;
            r_rdy_age[k] <= '0;
         end
      end else begin
         r_vld[0]     <= w_insert;
         r_dst[0]     <= in_reg_dst;
         r_wr[0]      <= in_reg_wr;
         r_rdy_age[0] <= w_rdy_age;
         for (int unsigned k = 1; k < NUM_ENTRIES; k++) begin
            r_vld[k]     <= ~flush & (k < MAX_AGE) & r_vld[k-1];
            r_dst[k]     <= r_dst[k-1];
            r_wr[k]      <= r_wr[k-1];
            r_rdy_age[k] <= r_rdy_age[k-1];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_issue_valid   <= 1'b0;
         r_issue_unit_id <= '0;
         r_issue_reg_dst <= '0;
         r_issue_latency <= '0;
         r_issue_reg_wr  <= 1'b0;
         r_lat_err       <= 1'b0;
         r_stall_cnt     <= '0;
      end else begin
         r_issue_valid <= w_insert;
         if (w_insert) begin
            r_issue_unit_id <= in_unit_id;
            r_issue_reg_dst <= in_reg_dst;
            r_issue_latency <= in_latency;
            r_issue_reg_wr  <= in_reg_wr;
         end
         r_lat_err <= w_accept & ~w_lat_ok;
         if (in_valid && !in_ready && (r_stall_cnt != '1))
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign issue_valid   = r_issue_valid;
   assign issue_unit_id = r_issue_unit_id;
   assign issue_reg_dst = r_issue_reg_dst;
   assign issue_latency = r_issue_latency;
   assign issue_reg_wr  = r_issue_reg_wr;
   assign lat_err       = r_lat_err;
   assign stall_cnt     = r_stall_cnt;

endmodule

// File: tb/tb_even_issue_ctrl.sv
// Self-checking bench for even_issue_ctrl: directed literal cases plus randomized traffic vs. a queue model.
module tb_even_issue_ctrl;
`ifdef EVEN_ISSUE_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, in_reg_wr, flush;
   logic [2:0]  in_unit_id, in_src_used;
   logic [6:0]  in_reg_dst, in_ra_addr, in_rb_addr, in_rc_addr;
   logic [3:0]  in_latency;
   logic        issue_valid, issue_reg_wr, lat_err;
   logic [2:0]  issue_unit_id;
   logic [6:0]  issue_reg_dst;
   logic [3:0]  issue_latency;
   logic [15:0] stall_cnt;

   even_issue_ctrl #(.NUM_ENTRIES(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_unit_id(in_unit_id), .in_reg_dst(in_reg_dst), .in_latency(in_latency),
      .in_reg_wr(in_reg_wr), .in_ra_addr(in_ra_addr), .in_rb_addr(in_rb_addr),
      .in_rc_addr(in_rc_addr), .in_src_used(in_src_used), .flush(flush),
      .issue_valid(issue_valid), .issue_unit_id(issue_unit_id),
      .issue_reg_dst(issue_reg_dst), .issue_latency(issue_latency),
      .issue_reg_wr(issue_reg_wr), .lat_err(lat_err), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   typedef struct { int dst; bit wr; int t0; int lat; } rec_t;
   rec_t q[$];
   int cyc = 0;
   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   bit exp_ready, exp_iv, exp_wr, exp_le;
   int exp_unit, exp_dst, exp_lat, exp_stall;

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Producer result is usable once (consumer cycle - producer cycle) reaches this.
   function automatic int need(input int lat);
      return FWD ? lat + 1 : 9;
   endfunction

   function automatic bit model_hazard();
      bit h = 1'b0;
      foreach (q[i]) begin
         if (q[i].wr && (cyc - q[i].t0) < need(q[i].lat)) begin
            if (in_src_used[0] && int'(in_ra_addr) == q[i].dst) h = 1'b1;
            if (in_src_used[1] && int'(in_rb_addr) == q[i].dst) h = 1'b1;
            if (in_src_used[2] && int'(in_rc_addr) == q[i].dst) h = 1'b1;
         end
      end
      return h;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         chk("in_ready", int'(in_ready), int'(exp_ready));
         chk("issue_valid", int'(issue_valid), int'(exp_iv));
         chk("issue_unit_id", int'(issue_unit_id), exp_unit);
         chk("issue_reg_dst", int'(issue_reg_dst), exp_dst);
         chk("issue_latency", int'(issue_latency), exp_lat);
         chk("issue_reg_wr", int'(issue_reg_wr), int'(exp_wr));
         chk("lat_err", int'(lat_err), int'(exp_le));
         chk("stall_cnt", int'(stall_cnt), exp_stall);
      end
   end

   task automatic step(input bit v, input int unit, input int dst, input int lat,
                       input bit wr, input int ra, input int rb, input int rc,
                       input int used, input bit fl, output bit rdy_obs);
      bit acc, legal;
      in_valid = v; in_unit_id = 3'(unit); in_reg_dst = 7'(dst); in_latency = 4'(lat);
      in_reg_wr = wr; in_ra_addr = 7'(ra); in_rb_addr = 7'(rb); in_rc_addr = 7'(rc);
      in_src_used = 3'(used); flush = fl;
      exp_ready = !fl && !model_hazard();
      @(negedge clk);
      rdy_obs = in_ready;
      @(posedge clk);
      acc = v && exp_ready;
      legal = (lat >= 2) && (lat <= 7);
      if (fl) q.delete();
      if (acc && legal) q.push_back('{dst: dst, wr: wr, t0: cyc, lat: lat});
      exp_iv = acc && legal;
      if (exp_iv) begin
         exp_unit = unit; exp_dst = dst; exp_lat = lat; exp_wr = wr;
      end
      exp_le = acc && !legal;
      if (v && !exp_ready && exp_stall < 65535) exp_stall++;
      cyc++;
      while (q.size() > 0 && (cyc - q[0].t0) >= 9) void'(q.pop_front());
      #1;
   endtask

   task automatic idle();
      bit r;
      step(1'b0, 0, 0, 2, 1'b0, 0, 0, 0, 0, 1'b0, r);
   endtask

   task automatic do_reset();
      in_valid = 1'b0; flush = 1'b0;
      chk_en = 1'b0;
      rst = 1'b0;
      #2;
      chk("rst_issue_valid", int'(issue_valid), 0);
      chk("rst_issue_unit_id", int'(issue_unit_id), 0);
      chk("rst_issue_reg_dst", int'(issue_reg_dst), 0);
      chk("rst_issue_latency", int'(issue_latency), 0);
      chk("rst_issue_reg_wr", int'(issue_reg_wr), 0);
      chk("rst_lat_err", int'(lat_err), 0);
      chk("rst_stall_cnt", int'(stall_cnt), 0);
      q.delete();
      exp_ready = 1'b1; exp_iv = 1'b0; exp_wr = 1'b0; exp_le = 1'b0;
      exp_unit = 0; exp_dst = 0; exp_lat = 0; exp_stall = 0;
      @(posedge clk); @(posedge clk);
      cyc += 2;
      #1;
      rst = 1'b1;
      chk_en = 1'b1;
   endtask

   initial begin
      bit r;
      int acc_at;
      rst = 1'b1;
      in_valid = 1'b0; flush = 1'b0; in_unit_id = '0; in_reg_dst = '0; in_latency = '0;
      in_reg_wr = 1'b0; in_ra_addr = '0; in_rb_addr = '0; in_rc_addr = '0; in_src_used = '0;
      #3;

      // Single add to r5, latency 2
      do_reset();
      step(1'b1, 0, 5, 2, 1'b1, 1, 2, 3, 3'b011, 1'b0, r);
      chk("t1_ready", int'(r), 1);
      chk("t1_issue_valid", int'(issue_valid), 1);
      chk("t1_issue_reg_dst", int'(issue_reg_dst), 5);
      chk("t1_issue_latency", int'(issue_latency), 2);
      chk("t1_lat_err", int'(lat_err), 0);
      idle();
      chk("t1_issue_valid_drop", int'(issue_valid), 0);

      // Producer r10 L=6, consumer reading r10 from the next cycle
      do_reset();
      step(1'b1, 0, 10, 6, 1'b1, 0, 0, 0, 0, 1'b0, r);
      acc_at = -1;
      for (int i = 1; i <= 20; i++) begin
         step(1'b1, 1, 11, 2, 1'b0, 10, 0, 0, 3'b001, 1'b0, r);
         if (r) begin
            acc_at = i;
            break;
         end
      end
      chk("t2_accept_cycle", acc_at, FWD ? 7 : 9);
      chk("t2_stall_cnt", int'(stall_cnt), FWD ? 6 : 8);
      chk("t2_issue_reg_dst", int'(issue_reg_dst), 11);

      // Flush clears a long-latency producer
      do_reset();
      step(1'b1, 2, 20, 7, 1'b1, 0, 0, 0, 0, 1'b0, r);
      idle();
      step(1'b0, 0, 0, 2, 1'b0, 0, 0, 0, 0, 1'b1, r);
      chk("t3_issue_valid_flush", int'(issue_valid), 0);
      step(1'b1, 0, 21, 3, 1'b1, 20, 0, 0, 3'b001, 1'b0, r);
      chk("t3_ready_after_flush", int'(r), 1);
      chk("t3_stall_cnt", int'(stall_cnt), 0);

      // Illegal latencies are swallowed with a lat_err pulse
      do_reset();
      step(1'b1, 0, 10, 0, 1'b1, 0, 0, 0, 0, 1'b0, r);
      chk("t4_ready_lat0", int'(r), 1);
      chk("t4_issue_valid_lat0", int'(issue_valid), 0);
      chk("t4_lat_err_lat0", int'(lat_err), 1);
      step(1'b1, 0, 10, 9, 1'b1, 0, 0, 0, 0, 1'b0, r);
      chk("t4_ready_lat9", int'(r), 1);
      chk("t4_lat_err_lat9", int'(lat_err), 1);
      step(1'b1, 0, 12, 4, 1'b1, 10, 0, 0, 3'b001, 1'b0, r);
      chk("t4_table_unchanged", int'(r), 1);
      chk("t4_lat_err_clear", int'(lat_err), 0);
      chk("t4_issue_valid", int'(issue_valid), 1);

      // Unused sources never stall; stall counter saturates
      do_reset();
      step(1'b1, 0, 10, 7, 1'b1, 0, 0, 0, 0, 1'b0, r);
      step(1'b1, 0, 13, 2, 1'b1, 10, 10, 10, 3'b000, 1'b0, r);
      chk("t5_unused_src_ready", int'(r), 1);
      step(1'b1, 0, 13, 2, 1'b1, 0, 10, 0, 3'b010, 1'b0, r);
      chk("t5_rb_hazard", int'(r), 0);
      for (int i = 0; i < 65540; i++)
         step(1'b1, 0, 1, 2, 1'b1, 0, 0, 0, 0, 1'b1, r);
      chk("t5_stall_sat", int'(stall_cnt), 65535);
      step(1'b1, 0, 1, 2, 1'b1, 0, 0, 0, 0, 1'b1, r);
      chk("t5_stall_sat_hold", int'(stall_cnt), 65535);

      // Randomized traffic over a small register set to force repeated matches
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         int lat;
         if (i == 2000) do_reset();
         if ($urandom_range(99) < 85) lat = int'($urandom_range(7, 2));
         else lat = ($urandom_range(1) == 0) ? int'($urandom_range(1)) : int'($urandom_range(15, 8));
         step($urandom_range(99) < 75, int'($urandom_range(3)), int'($urandom_range(7)), lat,
              $urandom_range(99) < 80, int'($urandom_range(7)), int'($urandom_range(7)),
              int'($urandom_range(7)), int'($urandom_range(7)), $urandom_range(99) < 4, r);
      end

      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/even_issue_ctrl.md
EVEN_ISSUE_CTRL -- requirements
Module: even_issue_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_ENTRIES, default 8, meaning the depth of the in-flight tracking table; legal range 8..15.
REQ-002 clk  input  1  single clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low; the block is in reset while rst=0.
REQ-004 in_valid  input  1  decoded even-pipe instruction present.
REQ-005 in_ready  output  1  block accepts the instruction this cycle.
REQ-006 in_unit_id  input  3  target unit (000 FX1, 001 FX2, 010 SP, 011 BYTE).
REQ-007 in_reg_dst  input  7  destination register address.
REQ-008 in_latency  input  4  unit result latency in cycles; legal 2..7.
REQ-009 in_reg_wr  input  1  instruction writes in_reg_dst.
REQ-010 in_ra_addr, in_rb_addr, in_rc_addr  input  7 each  source register addresses.
REQ-011 in_src_used  input  3  bit 0 ra, bit 1 rb, bit 2 rc actually read.
REQ-012 flush  input  1  discard all in-flight tracking and any pending issue.
REQ-013 issue_valid  output  1  registered issue strobe to the even pipe.
REQ-014 issue_unit_id / issue_reg_dst / issue_latency / issue_reg_wr  output  3/7/4/1  registered copies of the accepted fields.
REQ-015 lat_err  output  1  one-cycle pulse when an instruction with illegal latency is dropped.
REQ-016 stall_cnt  output  16  saturating count of stalled cycles.

Function
REQ-017 Acceptance SHALL occur in a cycle when in_valid=1, in_ready=1 and flush=0.
REQ-018 in_ready SHALL be combinational and equal to 0 when flush=1 or a RAW hazard exists, else 1.
REQ-019 A RAW hazard SHALL exist when any used source address equals reg_dst of a valid table entry with reg_wr=1 that is not yet ready.
REQ-020 An entry accepted at cycle t0 with latency L SHALL be ready at cycle t when t-t0 >= L+1 (forwarding build) or t-t0 >= 9 (no-forwarding build).
REQ-021 On acceptance, the table SHALL record {reg_dst, reg_wr, L, age=0}; every entry age SHALL increment each cycle; an entry SHALL be invalidated when age reaches 9.
REQ-022 The table SHALL be a shift structure (one acceptance per cycle max), so NUM_ENTRIES>=8 never overflows; no full condition exists.
REQ-023 issue_* outputs SHALL be updated one cycle after acceptance; issue_valid SHALL be 1 for exactly that one cycle per accepted instruction, else 0.
REQ-024 An instruction with in_latency outside 2..7 SHALL be accepted (in_ready=1), not entered in the table, not issued, and SHALL pulse lat_err the following cycle.
REQ-025 stall_cnt SHALL increment by 1 each cycle in_valid=1 and in_ready=0, saturating at 16'hFFFF.
REQ-026 flush=1 SHALL, at the next edge, invalidate all table entries and force issue_valid=0; an instruction present during flush is not accepted.
REQ-027 A source matching multiple entries SHALL stall until all matching entries are ready.
REQ-028 An instruction whose source equals its own reg_dst SHALL check only older entries.

Reset
REQ-029 While rst=0: all table entries invalid, issue_valid=0, issue_unit_id/reg_dst/latency/reg_wr=0, lat_err=0, stall_cnt=0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight tracking immediately; first acceptance possible on the first edge after rst returns to 1.

Configuration
REQ-031 Macro EVEN_ISSUE_FWD_EN: defined -> readiness per forwarding rule (t-t0 >= L+1); undefined -> readiness only after writeback (t-t0 >= 9) for all latencies.

Verification
REQ-032 Reset then single add to r5, L=2 -> issue_valid=1 one cycle later, issue_reg_dst=5, issue_latency=2, lat_err=0.
REQ-033 FWD_EN: producer r10 L=6 at cycle 0, consumer reading r10 (ra) asserted from cycle 1 -> in_ready=0 cycles 1..6, accepted cycle 7, stall_cnt=6.
REQ-034 FWD_EN undefined, same stimulus as REQ-033 -> accepted cycle 9, stall_cnt=8.
REQ-035 Producer r20 L=7 at cycle 0, flush at cycle 2, consumer reading r20 at cycle 3 -> accepted cycle 3, no stall after flush.
REQ-036 in_latency=0 or 9 -> in_ready=1, no issue_valid, lat_err pulses 1 cycle, table unchanged.
REQ-037 Consumer with in_src_used=000 reading r10 during hazard window -> accepted immediately; stall_cnt forced to 16'hFFFF then one more stall -> stays 16'hFFFF.
